// File: rtl/lag_tg_pkg.sv
// Shared types and LFSR helper for the LAG open-loop traffic generator.
package lag_tg_pkg;

  typedef struct packed {
    logic [31:0] ts;
    logic [7:0]  dx;
    logic [7:0]  dy;
  } pend_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY
  } tg_state_t;

  // Feedback taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lag_tg_fifo.sv
// Registered FIFO for pending packets; a push while full succeeds when a pop
// happens in the same cycle. DEPTH must be a power of 2, at least 2.
module lag_tg_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/lag_traffic_gen.sv
// Open-loop Bernoulli traffic source for one router local port: LFSR-driven
// generation into a timestamped queue, drained one packet per VC round-robin.
module lag_traffic_gen
  import lag_tg_pkg::*;
#(
  parameter int unsigned nv            = 4,
  parameter int unsigned xdim          = 4,
  parameter int unsigned ydim          = 4,
  parameter int unsigned xpos          = 0,
  parameter int unsigned ypos          = 0,
  parameter int unsigned packet_length = 8,
  parameter int unsigned pend_depth    = 8,
  parameter logic [15:0] seed          = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [15:0]   rate_thresh,
  input  logic [nv-1:0] network_ready,
  output logic [15:0]   flit_data,
  output logic          flit_head,
  output logic          flit_tail,
  output logic          flit_valid,
  output logic [nv-1:0] flit_vc,
  output logic [15:0]   pkts_sent,
  output logic [15:0]   pkts_dropped
);

  localparam int unsigned VW    = (nv > 1) ? $clog2(nv) : 1;
  localparam logic [7:0]  XD    = 8'(xdim);
  localparam logic [7:0]  YD    = 8'(ydim);
  localparam logic [7:0]  XP    = 8'(xpos);
  localparam logic [7:0]  YP    = 8'(ypos);
  localparam logic [7:0]  XNEXT = 8'((xpos + 1) % xdim);
  localparam logic [7:0]  LASTK = 8'(packet_length - 1);

  tg_state_t   r_state, w_next;
  logic [15:0] r_lfsr;
  logic [31:0] r_cycle;
  logic [VW-1:0] r_rr, r_vc_idx, w_sel, w_rr_next;
  logic [7:0]  r_k;
  logic [15:0] r_id, r_sent, r_dropped;
  logic [31:0] r_ts;
  logic [7:0]  r_dx, r_dy;

  logic        w_gen, w_full, w_empty, w_pop, w_found, w_rdy, w_last;
  logic [7:0]  w_dx_raw, w_dx, w_dy, w_body_hi;
  pend_entry_t w_push_ent, w_head_ent;

  assign w_gen    = enable && (r_lfsr < rate_thresh);
  assign w_dx_raw = r_lfsr[7:0] % XD;
  assign w_dy     = r_lfsr[15:8] % YD;
  // Never address ourselves: step X on a self-hit
  assign w_dx       = ((w_dx_raw == XP) && (w_dy == YP)) ? XNEXT : w_dx_raw;
  assign w_push_ent = '{ts: r_cycle, dx: w_dx, dy: w_dy};

  lag_tg_fifo #(
    .WIDTH($bits(pend_entry_t)),
    .DEPTH(pend_depth)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_gen),
    .i_pop  (w_pop),
    .i_data (w_push_ent),
    .o_data (w_head_ent),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned i = 0; i < nv; i++) begin
      if (!w_found && network_ready[VW'((32'(r_rr) + i) % nv)]) begin
        w_found = 1'b1;
        w_sel   = VW'((32'(r_rr) + i) % nv);
      end
    end
  end

  assign w_rdy     = network_ready[r_vc_idx];
  assign w_last    = (r_k == LASTK);
  assign w_rr_next = (32'(r_vc_idx) == nv - 1) ? '0 : r_vc_idx + VW'(1);

  always_comb begin
    case (r_k)
      8'd1:    w_body_hi = r_id[7:0];
      8'd2:    w_body_hi = r_id[15:8];
      8'd3:    w_body_hi = r_ts[7:0];
      8'd4:    w_body_hi = r_ts[15:8];
      8'd5:    w_body_hi = r_ts[23:16];
      8'd6:    w_body_hi = r_ts[31:24];
      default: w_body_hi = '0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    flit_valid = 1'b0;
    flit_head  = 1'b0;
    flit_tail  = 1'b0;
    flit_data  = '0;
    flit_vc    = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty && w_found) begin
          w_pop  = 1'b1;
          w_next = HEAD;
        end
      end
      HEAD: begin
        flit_valid = 1'b1;
        flit_head  = 1'b1;
        flit_vc    = nv'(1) << r_vc_idx;
        flit_data  = {r_dx - XP, r_dy - YP};
        if (w_rdy) w_next = BODY;
      end
      BODY: begin
        flit_valid = 1'b1;
        flit_tail  = w_last;
        flit_vc    = nv'(1) << r_vc_idx;
        flit_data  = {w_body_hi, r_k};
        if (w_rdy && w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lfsr    <= seed;
      r_cycle   <= '0;
      r_rr      <= '0;
      r_vc_idx  <= '0;
      r_k       <= '0;
      r_id      <= '0;
      r_sent    <= '0;
      r_dropped <= '0;
      r_ts      <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
    end else begin
      r_state <= w_next;
      r_lfsr  <= lfsr_next(r_lfsr);
      r_cycle <= r_cycle + 32'd1;
      if (w_gen && w_full && !w_pop && (r_dropped != 16'hFFFF))
        r_dropped <= r_dropped + 16'd1;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_vc_idx <= w_sel;
            r_ts     <= w_head_ent.ts;
            r_dx     <= w_head_ent.dx;
            r_dy     <= w_head_ent.dy;
          end
        end
        HEAD: if (w_rdy) r_k <= 8'd1;
        BODY: begin
          if (w_rdy) begin
            if (w_last) begin
              r_sent <= r_sent + 16'd1;
              r_id   <= r_id + 16'd1;
              r_rr   <= w_rr_next;
            end else begin
              r_k <= r_k + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pkts_sent    = r_sent;
  assign pkts_dropped = r_dropped;

endmodule

// File: tb/tb_lag_traffic_gen.sv
// Scoreboard bench: a cycle-level queue model predicts flits and counters,
// a negedge monitor compares whatever the generator presents.
module tb_lag_traffic_gen;

  localparam int NV   = 4;
  localparam int XDIM = 4;
  localparam int YDIM = 4;
  localparam int XPOS = 0;
  localparam int YPOS = 0;
  localparam int PL   = 8;
  localparam int PEND = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [15:0]   rate_thresh;
  logic [NV-1:0] network_ready;
  logic [15:0]   flit_data, pkts_sent, pkts_dropped;
  logic          flit_head, flit_tail, flit_valid;
  logic [NV-1:0] flit_vc;
  logic [15:0]   d2_data, d2_sent, d2_dropped;
  logic          d2_head, d2_tail, d2_valid;
  logic [NV-1:0] d2_vc;

  always #5 clk = ~clk;

  lag_traffic_gen #(
    .nv(NV), .xdim(XDIM), .ydim(YDIM), .xpos(XPOS), .ypos(YPOS),
    .packet_length(PL), .pend_depth(PEND), .seed(SEED)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rate_thresh(rate_thresh),
    .network_ready(network_ready), .flit_data(flit_data), .flit_head(flit_head),
    .flit_tail(flit_tail), .flit_valid(flit_valid), .flit_vc(flit_vc),
    .pkts_sent(pkts_sent), .pkts_dropped(pkts_dropped)
  );

  // Corner source at (3,3), 2-flit packets, seed chosen so its first
  // destination collides with itself.
  lag_traffic_gen #(
    .nv(NV), .xdim(4), .ydim(4), .xpos(3), .ypos(3),
    .packet_length(2), .pend_depth(8), .seed(16'h0303)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .rate_thresh(rate_thresh),
    .network_ready(network_ready), .flit_data(d2_data), .flit_head(d2_head),
    .flit_tail(d2_tail), .flit_valid(d2_valid), .flit_vc(d2_vc),
    .pkts_sent(d2_sent), .pkts_dropped(d2_dropped)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct { int unsigned ts; int dx; int dy; } ent_t;
  typedef struct packed {
    logic [15:0] data;
    logic        head;
    logic        tail;
    logic [3:0]  vc;
  } flit_t;

  ent_t        m_q[$];
  flit_t       exp_q[$];
  logic [15:0] m_lfsr;
  int unsigned m_cyc;
  bit          m_active;
  int          m_left, m_vc, m_rr;
  logic [15:0] m_id, m_sent, m_dropped;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return 16'((int'(s) << 1) | fb);
  endfunction

  function automatic flit_t make_flit(input ent_t e, input int k, input logic [15:0] id, input int vc);
    flit_t f;
    int hi;
    f.vc = 4'(1 << vc);
    if (k == 0) begin
      f.data = {8'(e.dx - XPOS), 8'(e.dy - YPOS)};
      f.head = 1'b1;
      f.tail = 1'b0;
    end else begin
      if (k == 1)                hi = int'(id) & 255;
      else if (k == 2)           hi = (int'(id) >> 8) & 255;
      else if (k >= 3 && k <= 6) hi = int'((e.ts >> (8 * (k - 3))) & 255);
      else                       hi = 0;
      f.data = {8'(hi), 8'(k)};
      f.head = 1'b0;
      f.tail = (k == PL - 1);
    end
    return f;
  endfunction

  always @(posedge clk) begin : model
    ent_t e;
    bit   found;
    int   idx;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_lfsr = SEED; m_cyc = 0; m_active = 0; m_left = 0; m_vc = 0; m_rr = 0;
      m_id = 0; m_sent = 0; m_dropped = 0;
    end else begin
      if (m_active) begin
        if (network_ready[m_vc]) begin
          m_left--;
          if (m_left == 0) begin
            m_active = 0;
            m_sent   = m_sent + 16'd1;
            m_id     = m_id + 16'd1;
            m_rr     = (m_vc + 1) % NV;
          end
        end
      end else if (m_q.size() > 0) begin
        found = 0;
        for (int i = 0; i < NV; i++) begin
          idx = (m_rr + i) % NV;
          if (!found && network_ready[idx]) begin
            found = 1;
            m_vc  = idx;
          end
        end
        if (found) begin
          e = m_q.pop_front();
          m_active = 1;
          m_left   = PL;
          for (int k = 0; k < PL; k++) exp_q.push_back(make_flit(e, k, m_id, m_vc));
        end
      end
      if (enable && (m_lfsr < rate_thresh)) begin
        e.ts = m_cyc;
        e.dx = int'(m_lfsr[7:0]) % XDIM;
        e.dy = int'(m_lfsr[15:8]) % YDIM;
        if (e.dx == XPOS && e.dy == YPOS) e.dx = (XPOS + 1) % XDIM;
        if (m_q.size() < PEND) m_q.push_back(e);
        else if (m_dropped != 16'hFFFF) m_dropped = m_dropped + 16'd1;
      end
      m_lfsr = lfsr_step(m_lfsr);
      m_cyc++;
    end
  end

  always @(negedge clk) begin : monitor
    flit_t f;
    if (started) begin
      check("flit_valid", 32'(flit_valid), 32'(m_active));
      check("pkts_sent", 32'(pkts_sent), 32'(m_sent));
      check("pkts_dropped", 32'(pkts_dropped), 32'(m_dropped));
      if (flit_valid) begin
        if (exp_q.size() == 0) begin
          check("flit_unexpected", 32'(flit_valid), 32'(0));
        end else begin
          f = exp_q[0];
          check("flit", 32'({flit_data, flit_head, flit_tail, flit_vc}), 32'(f));
          if (!rst && ((network_ready & f.vc) != 0)) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    bit hit;
    rst = 1'b1; enable = 1'b1; rate_thresh = 16'h0000; network_ready = '1;
    @(posedge clk);
    #1 started = 1'b1;
    tick(2);
    rst = 1'b0;

    // Idle source: nothing must appear
    tick(1000);

    // Saturated rate, all ready; corner source checked directly
    rate_thresh = 16'hFFFF;
    do_reset();
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (d2_valid) hit = 1;
    end
    check("d2_head_seen", 32'(hit), 32'(1));
    if (hit) begin
      check("d2_head", 32'({d2_head, d2_tail, d2_vc, d2_data}), {10'd0, 1'b1, 1'b0, 4'b0001, 16'hFD00});
      @(negedge clk);
      check("d2_tail", 32'({d2_head, d2_tail, d2_vc, d2_data}), {10'd0, 1'b0, 1'b1, 4'b0001, 16'h0001});
      @(negedge clk);
      check("d2_sent", 32'(d2_sent), 32'(1));
      check("d2_dropped", 32'(d2_dropped), 32'(0));
    end
    tick(300);

    // Network blocked: queue fills, rest are dropped
    do_reset();
    network_ready = '0;
    tick(200);
    network_ready = '1;
    tick(100);

    // Ready toggling every cycle mid-packet
    for (int i = 0; i < 150; i++) begin
      network_ready = (i % 2 == 0) ? 4'b0000 : 4'b1111;
      tick(1);
    end

    // Random rate, enable and per-VC ready
    for (int i = 0; i < 2000; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 4))
          0: rate_thresh = 16'h0000;
          1: rate_thresh = 16'h2000;
          2: rate_thresh = 16'h8000;
          3: rate_thresh = 16'hFFFF;
          default: rate_thresh = 16'($urandom);
        endcase
      end
      enable        = ($urandom_range(0, 3) != 0);
      network_ready = 4'($urandom_range(0, 15));
      tick(1);
    end

    // Reset while body flit 4 is on the wire
    enable = 1'b1; rate_thresh = 16'hFFFF; network_ready = '1;
    do_reset();
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick(1);
      if (flit_valid && !flit_head && flit_data[7:0] == 8'd4) hit = 1;
    end
    check("body4_seen", 32'(hit), 32'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
